cmac_bp_drain: RTL and testbench

Drain controller for the CMAC backpressure monitor's event FIFO. Generates the rising-edge `fifo_next` pops the monitor expects and captures each entry. Discards events shorter than a programmable minimum, forwards the rest on an AXI-stream, and keeps saturating event statistics. Sits between the monitor and the register/DMA logic that reports backpressure to software.

---
 rtl/cmac_bp_drain.sv | 164 ++++++++++++++++
 tb/tb_cmac_bp_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_bp_drain.sv
// cmac_bp_drain
// Drains the CMAC backpressure monitor's event FIFO one entry at a time.
// Each drain generates a one-cycle rising-edge pop (mon_fifo_next) followed
// by a settle gap so the monitor always sees a fresh edge. It also keeps
// saturating statistics.
//
// Events shorter than MIN_LEN are popped and counted but not forwarded.
// Forwarded events are presented on a 97-bit AXI-stream word
// {rxad, length, ts}.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   enable                - level; 0 blocks new drains (an active one completes)
//   clear_stats           - one-cycle pulse zeroing the statistics
//   mon_fifo_valid        - monitor FIFO non-empty
//   mon_bp_length/rxad/ts - head-entry fields
//   mon_fifo_next         - registered pop request (monitor acts on rising edge)
//   out_tdata/tvalid/tready - AXI-stream output
//   evt_count, drop_count, rxad_count, max_len - statistics
//   busy                  - drain sequence in progress
module cmac_bp_drain #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MIN_LEN       = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_stats,
    input  logic              mon_fifo_valid,
    input  logic [31:0]       mon_bp_length,
    input  logic              mon_bp_rxad,
    input  logic [63:0]       mon_bp_ts,
    output logic              mon_fifo_next,
    output logic [96:0]       out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [CNT_W-1:0]  evt_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  rxad_count,
    output logic [31:0]       max_len,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    localparam logic [31:0] MIN_LEN_U  = 32'(MIN_LEN);
    localparam logic [3:0]  SETTLE_LD  = 4'(SETTLE_CYCLES);

    state_t             state_reg, state_next;
    logic [3:0]         settle_reg, settle_next;
    logic               fifo_next_reg;
    logic               tvalid_reg;
    logic [96:0]        data_reg;
    logic [CNT_W-1:0]   evt_reg, drop_reg, rxad_reg;
    logic [CNT_W-1:0]   evt_next, drop_next, rxad_next;
    logic [CNT_W-1:0]   evt_base, drop_base, rxad_base;
    logic [31:0]        max_reg, max_next, max_base;
    logic               start;
    logic               fwd;

    // A drain may only start when the previous output word has been taken,
    // so an entry is never popped without somewhere to put it.
    assign start = (state_reg == IDLE) && enable && mon_fifo_valid && !tvalid_reg;
    assign fwd   = (mon_bp_length >= MIN_LEN_U);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = POP;
            end
            POP: begin
                state_next  = SETTLE;
                settle_next = SETTLE_LD;
            end
            SETTLE: begin
                settle_next = settle_reg - 4'd1;
                // Leaving on the cycle the count hits zero gives exactly
                // SETTLE_CYCLES cycles in this state.
                if (settle_reg <= 4'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Capture / pop / stream ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_next_reg <= 1'b0;
            tvalid_reg    <= 1'b0;
            data_reg      <= '0;
        end else begin
            // High only for the POP cycle; the SETTLE gap supplies the low phase.
            fifo_next_reg <= start;
            if (start) begin
                data_reg   <= {mon_bp_rxad, mon_bp_length, mon_bp_ts};
                tvalid_reg <= fwd;
            end else if (tvalid_reg && out_tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    // ---------------- Statistics ----------------
    // A clear coinciding with an update acts as clear-then-update.
    always_comb begin
        evt_base  = clear_stats ? '0 : evt_reg;
        drop_base = clear_stats ? '0 : drop_reg;
        rxad_base = clear_stats ? '0 : rxad_reg;
        max_base  = clear_stats ? '0 : max_reg;
        evt_next  = sat_inc(evt_base,  start && fwd);
        drop_next = sat_inc(drop_base, start && !fwd);
        rxad_next = sat_inc(rxad_base, start && fwd && mon_bp_rxad);
        max_next  = max_base;
        if (start && fwd && (mon_bp_length > max_base))
            max_next = mon_bp_length;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_reg  <= '0;
            drop_reg <= '0;
            rxad_reg <= '0;
            max_reg  <= '0;
        end else begin
            evt_reg  <= evt_next;
            drop_reg <= drop_next;
            rxad_reg <= rxad_next;
            max_reg  <= max_next;
        end
    end

    assign mon_fifo_next = fifo_next_reg;
    assign out_tvalid    = tvalid_reg;
    assign out_tdata     = data_reg;
    assign evt_count     = evt_reg;
    assign drop_count    = drop_reg;
    assign rxad_count    = rxad_reg;
    assign max_len       = max_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_cmac_bp_drain.sv
module tb_cmac_bp_drain;

    localparam int SETTLE = 2;
    localparam int MINL   = 10;
    localparam int CW     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_stats;
    logic        mon_fifo_valid;
    logic [31:0] mon_bp_length;
    logic        mon_bp_rxad;
    logic [63:0] mon_bp_ts;
    logic        mon_fifo_next;
    logic [96:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic [CW-1:0] evt_count, drop_count, rxad_count;
    logic [31:0] max_len;
    logic        busy;

    always #5 clk = ~clk;

    cmac_bp_drain #(.SETTLE_CYCLES(SETTLE), .MIN_LEN(MINL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .mon_fifo_valid(mon_fifo_valid), .mon_bp_length(mon_bp_length),
        .mon_bp_rxad(mon_bp_rxad), .mon_bp_ts(mon_bp_ts),
        .mon_fifo_next(mon_fifo_next), .out_tdata(out_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .evt_count(evt_count), .drop_count(drop_count), .rxad_count(rxad_count),
        .max_len(max_len), .busy(busy)
    );

    // Monitor FIFO model: head pops on each rising edge of mon_fifo_next.
    logic [96:0] fmem [0:15];
    int fhead = 0;
    int ftail = 0;
    logic [3:0] fhead_idx;
    assign fhead_idx      = fhead[3:0];
    assign mon_fifo_valid = (fhead != ftail);
    assign {mon_bp_rxad, mon_bp_length, mon_bp_ts} = fmem[fhead_idx];

    logic [96:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    int pop_cnt = 0, nxt_hi = 0, busy_hi = 0, vld_hi = 0;
    int cyc = 0, last_pop = -1, min_gap = 1000;
    logic nxt_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (mon_fifo_next && !nxt_prev) begin
            fhead++;
            pop_cnt++;
            if (last_pop >= 0 && (cyc - last_pop) < min_gap)
                min_gap = cyc - last_pop;
            last_pop = cyc;
        end
        if (mon_fifo_next) nxt_hi++;
        if (busy) busy_hi++;
        if (out_tvalid) vld_hi++;
        nxt_prev = mon_fifo_next;
        cyc++;
    end

    // Scoreboard monitor: inputs are stable from negedge+1 to the next posedge,
    // so valid&ready here means a transfer at the coming edge.
    always @(negedge clk) begin
        #1;
        if (!reset && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream: unexpected word %0h, expected none", out_tdata);
            end else begin
                chk("stream", 128'(out_tdata), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic rx, input logic [31:0] len, input logic [63:0] ts);
        fmem[ftail[3:0]] = {rx, len, ts};
        ftail++;
        if (len >= 32'(MINL))
            exp_q.push_back({rx, len, ts});
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fhead == ftail && !busy && !out_tvalid && exp_q.size() == 0) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: drain timeout, got not idle, expected idle", name);
    endtask

    task automatic clr_stats();
        @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
    endtask

    task automatic zero_tb_counts();
        pop_cnt = 0; nxt_hi = 0; busy_hi = 0; vld_hi = 0;
        last_pop = -1; min_gap = 1000;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; out_tready = 1'b1;
        for (int i = 0; i < 16; i++) fmem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_next",   128'(mon_fifo_next), 128'(0));
        chk("rst_tvalid", 128'(out_tvalid), 128'(0));
        chk("rst_tdata",  128'(out_tdata), 128'(0));
        chk("rst_evt",    128'(evt_count), 128'(0));
        chk("rst_drop",   128'(drop_count), 128'(0));
        chk("rst_rxad",   128'(rxad_count), 128'(0));
        chk("rst_max",    128'(max_len), 128'(0));
        chk("rst_busy",   128'(busy), 128'(0));
        reset = 1'b0;
        enable = 1'b1;

        // Single forwarded event
        @(negedge clk);
        zero_tb_counts();
        push(1'b0, 32'd100, 64'd5);
        wait_idle("single");
        chk("single_pops",   128'(pop_cnt), 128'(1));
        chk("single_nxt_hi", 128'(nxt_hi), 128'(1));
        chk("single_vld_hi", 128'(vld_hi), 128'(1));
        chk("single_busy",   128'(busy_hi), 128'(3));
        chk("single_evt",    128'(evt_count), 128'(1));
        chk("single_max",    128'(max_len), 128'(100));

        // Filtering
        clr_stats();
        zero_tb_counts();
        push(1'b0, 32'd3, 64'd11);
        push(1'b0, 32'd50, 64'd12);
        wait_idle("filter");
        chk("filter_pops", 128'(pop_cnt), 128'(2));
        chk("filter_drop", 128'(drop_count), 128'(1));
        chk("filter_evt",  128'(evt_count), 128'(1));

        // Backpressure hold
        clr_stats();
        zero_tb_counts();
        out_tready = 1'b0;
        push(1'b0, 32'd20, 64'd21);
        push(1'b0, 32'd30, 64'd22);
        push(1'b0, 32'd40, 64'd23);
        repeat (20) @(negedge clk);
        chk("bp_stall_pops", 128'(pop_cnt), 128'(1));
        chk("bp_hold_valid", 128'(out_tvalid), 128'(1));
        chk("bp_hold_data",  128'(out_tdata), 128'({1'b0, 32'd20, 64'd21}));
        out_tready = 1'b1;
        wait_idle("bp");
        chk("bp_pops",   128'(pop_cnt), 128'(3));
        chk("bp_gap_ok", 128'(min_gap >= 4), 128'(1));

        // rxad / max tracking
        clr_stats();
        push(1'b1, 32'd40, 64'd31);
        push(1'b0, 32'd90, 64'd32);
        push(1'b1, 32'd60, 64'd33);
        wait_idle("rxad");
        chk("rxad_cnt", 128'(rxad_count), 128'(2));
        chk("rxad_max", 128'(max_len), 128'(90));
        chk("rxad_evt", 128'(evt_count), 128'(3));

        // Clear coincident with a start edge (evt_count was 3 beforehand)
        @(negedge clk);
        enable = 1'b0;
        push(1'b0, 32'd70, 64'd41);
        @(negedge clk);
        enable = 1'b1;
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        wait_idle("clr_coinc");
        chk("clr_coinc_evt", 128'(evt_count), 128'(1));
        chk("clr_coinc_max", 128'(max_len), 128'(70));

        // Saturation at CNT_W=2
        clr_stats();
        for (int i = 0; i < 5; i++) push(1'b0, 32'(11 + i), 64'(50 + i));
        wait_idle("sat");
        chk("sat_evt", 128'(evt_count), 128'(3));
        chk("sat_max", 128'(max_len), 128'(15));

        // Reset during POP
        clr_stats();
        zero_tb_counts();
        push(1'b1, 32'd80, 64'd61);
        begin
            int n;
            n = 0;
            while (!mon_fifo_next && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!mon_fifo_next) begin
                total++;
                bad++;
                $display("FAIL rstpop_wait: got no pop, expected pop");
            end
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rstpop_next",   128'(mon_fifo_next), 128'(0));
        chk("rstpop_tvalid", 128'(out_tvalid), 128'(0));
        chk("rstpop_evt",    128'(evt_count), 128'(0));
        chk("rstpop_rxad",   128'(rxad_count), 128'(0));
        chk("rstpop_busy",   128'(busy), 128'(0));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        zero_tb_counts();
        push(1'b0, 32'd85, 64'd62);
        wait_idle("rstpop_resume");
        chk("rstpop_pops", 128'(pop_cnt), 128'(1));
        chk("rstpop_evt2", 128'(evt_count), 128'(1));
        chk("rstpop_max2", 128'(max_len), 128'(85));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
